// File: rtl/pulse_one_shot_pkg.sv
// Shared defaults and sizing helper for the pulse one-shot conditioner.
package pulse_one_shot_pkg;

    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
    localparam int unsigned DEFAULT_STABLE_CYCLES = 8;

    // Counter width able to hold 0..stable_cycles.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/pulse_one_shot_debounce.sv
// Synchroniser + stability-counter debouncer producing the accepted level.
module debounce_filter
    import pulse_one_shot_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    output logic o_level,
    output logic o_accept
);

    localparam int unsigned     CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic [CW-1:0]          r_cnt;
    logic                   w_sync_out;
    logic                   w_differs;
    logic                   w_accept;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_differs  = (w_sync_out != r_level);
    // Accept on the STABLE_CYCLES-th consecutive differing sample.
    assign w_accept   = w_differs && (r_cnt == CNT_LAST);

    // Synchronise the raw input and qualify any new level by run length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse};
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_sync_out;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level  = r_level;
    assign o_accept = w_accept;

endmodule

// File: rtl/pulse_one_shot.sv
// Debounced rising-edge one-shot: one clk-wide strobe per accepted 0->1.
module pulse_one_shot
    import pulse_one_shot_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic pulse_out
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("pulse_one_shot: SYNC_STAGES must be 2 or more");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("pulse_one_shot: STABLE_CYCLES must be 1 or more");
    end

    logic w_level;
    logic w_accept;
    logic w_rise;
    logic r_pulse_out;

    debounce_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .i_pulse  (pulse),
        .o_level  (w_level),
        .o_accept (w_accept)
    );

    // Strobe is taken from the update condition so it rises on the same
    // edge as the accepted level rather than one cycle later.
    assign w_rise = w_accept && !w_level;

    // Register the one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse_out <= 1'b0;
        end else begin
            r_pulse_out <= w_rise;
        end
    end

    assign pulse_out = r_pulse_out;

endmodule

// File: tb/tb_pulse_one_shot.sv
// Self-checking bench for pulse_one_shot: vector table, corner sequences,
// and randomized stimulus against a window-based reference model.
`timescale 1ns/100ps
module tb_pulse_one_shot;

    localparam int N = 2;   // synchroniser stages
    localparam int S = 8;   // stable cycles

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic pulse = 1'b0;
    logic pulse_out;

    always #1 clk = ~clk;   // 2 ns period

    pulse_one_shot #(
        .SYNC_STAGES   (N),
        .STABLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse     (pulse),
        .pulse_out (pulse_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: history of sampled inputs per edge.
    bit p_hist [0:15999];
    int edge_no  = -1;
    int last_rst = -1;
    bit m_level  = 1'b0;
    bit m_out    = 1'b0;

    int strobe_cnt   = 0;
    int first_strobe = -1;

    typedef struct {
        bit rst;
        bit pulse;
        bit exp_out;
        bit exp_level;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Value seen by the debouncer at edge idx: the input sampled N edges
    // earlier, or 0 if that sample predates / coincides with the last reset.
    function automatic bit seen_at(input int idx);
        if (idx - N > last_rst) return p_hist[idx - N];
        return 1'b0;
    endfunction

    // Level flips when the last S seen values (all after reset) are the
    // opposite of the current level; a 0->1 flip is a strobe.
    task automatic model_edge(input bit r, input bit p);
        bit all_flip;
        int idx;
        edge_no++;
        p_hist[edge_no] = p;
        m_out = 1'b0;
        if (r) begin
            last_rst = edge_no;
            m_level  = 1'b0;
        end else begin
            all_flip = 1'b1;
            for (int j = 0; j < S; j++) begin
                idx = edge_no - j;
                if (idx < 0 || idx <= last_rst || seen_at(idx) == m_level)
                    all_flip = 1'b0;
            end
            if (all_flip) begin
                m_level = !m_level;
                m_out   = m_level;
            end
        end
    endtask

    task automatic step(input bit r, input bit p);
        rst   = r;
        pulse = p;
        @(posedge clk);
        model_edge(r, p);
        @(negedge clk);
        check("model_pulse_out", {31'd0, pulse_out}, {31'd0, m_out});
        check("model_level", {31'd0, dut.w_level}, {31'd0, m_level});
        if (pulse_out === 1'b1) begin
            strobe_cnt++;
            if (first_strobe < 0) first_strobe = edge_no;
        end
    endtask

    task automatic run_const(input bit p, input int n);
        for (int i = 0; i < n; i++) step(1'b0, p);
    endtask

    task automatic clear_strobes();
        strobe_cnt   = 0;
        first_strobe = -1;
    endtask

    function automatic void add(input bit r, input bit p, input bit o, input bit l, input int n);
        vec_t v;
        v.rst = r; v.pulse = p; v.exp_out = o; v.exp_level = l;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    initial begin : main
        int e0;
        int e_run;
        bit bounce [6];
        bit r;
        bit p;
        int len;

        // Reset held with pulse high, then qualification, strobe, fall, glitch.
        add(1, 1, 0, 0, 5);
        add(0, 1, 0, 0, 9);
        add(0, 1, 1, 1, 1);
        add(0, 1, 0, 1, 3);
        add(0, 0, 0, 1, 9);
        add(0, 0, 0, 0, 3);
        add(0, 1, 0, 0, 5);
        add(0, 0, 0, 0, 15);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].pulse);
            check("tbl_pulse_out", {31'd0, pulse_out}, {31'd0, tbl[i].exp_out});
            check("tbl_level", {31'd0, dut.w_level}, {31'd0, tbl[i].exp_level});
        end

        // Bounce 1,0,1,1,0,1 then steady high.
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        clear_strobes();
        foreach (bounce[i]) step(1'b0, bounce[i]);
        e_run = edge_no;
        run_const(1'b1, 25);
        check("bounce_count", strobe_cnt, 1);
        check("bounce_time", first_strobe, e_run + 9);
        run_const(1'b0, 20);

        // Long hold.
        clear_strobes();
        e0 = edge_no + 1;
        run_const(1'b1, 1000);
        check("hold_count", strobe_cnt, 1);
        check("hold_time", first_strobe, e0 + 9);
        run_const(1'b0, 20);

        // Nominal 100 ns high / 100 ns low.
        for (int per = 0; per < 3; per++) begin
            clear_strobes();
            e0 = edge_no + 1;
            run_const(1'b1, 50);
            check("periodic_rise_count", strobe_cnt, 1);
            check("periodic_rise_time", first_strobe, e0 + 9);
            clear_strobes();
            run_const(1'b0, 50);
            check("periodic_fall_count", strobe_cnt, 0);
        end

        // Reset in the middle of qualification.
        clear_strobes();
        run_const(1'b1, 4);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("midrst_no_strobe", strobe_cnt, 0);
        e0 = edge_no + 1;
        run_const(1'b1, 30);
        check("midrst_count", strobe_cnt, 1);
        check("midrst_time", first_strobe, e0 + 9);
        run_const(1'b0, 20);

        // Randomized segments with occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            r   = ($urandom_range(0, 19) == 0);
            p   = 1'($urandom_range(0, 1));
            len = r ? $urandom_range(1, 3) : $urandom_range(1, 20);
            for (int i = 0; i < len; i++) step(r, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
